eq_scale_sequencer: RTL and testbench
=====================================

# eq_scale_sequencer

Time-multiplexed gain/volume controller for the EQ engine. It sits between the five band filters and the codec output. It replaces ten parallel band-scaling multipliers and two volume multipliers with one shared signed multiplier, sequenced by a state machine. Once per filtered stereo sample it scales each band by its pot gain, sums bands per channel, applies volume, and presents saturated 16-bit left/right results with a one-cycle valid strobe.

## Interface
- `GAIN_SHIFT`, 11: right-shift applied after each multiply; pot value 0x800 = unity.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `filt_vld` in 1: one-cycle strobe; all ten band inputs are valid.
- `LP_lft`, `B1_lft`, `B2_lft`, `B3_lft`, `HP_lft` in 16 each: signed left band outputs.
- `LP_rht`, `B1_rht`, `B2_rht`, `B3_rht`, `HP_rht` in 16 each: signed right band outputs.
- `LP_gain`, `B1_gain`, `B2_gain`, `B3_gain`, `HP_gain` in 12 each: unsigned band pot gains.
- `volume` in 12: unsigned volume pot.
- `lft_out`, `rht_out` out 16: signed saturated results; held until next update.
- `out_vld` out 1: one-cycle strobe; outputs updated this cycle.
- `busy` out 1: high from capture until `out_vld`, inclusive.
- `ovr` out 1: one-cycle pulse; `filt_vld` arrived while busy and was dropped.

## Operation
- States: IDLE, BAND, DRAIN, VOL, DONE.
- IDLE:
  - On `filt_vld`, capture all ten audio words, five gains and `volume` into holding registers. This is cycle 0.
  - Go to BAND and clear both accumulators.
  - Pots are sampled only at capture.
- BAND (cycles 1–10): issue one multiply per cycle in this fixed order:
  - L-LP, L-B1, L-B2, L-B3, L-HP
  - R-LP, R-B1, R-B2, R-B3, R-HP
- Multiply and scale rules:
  - Operand a = signed audio (16b). Operand b = {1'b0, gain} (13b signed). Full product is 29b.
  - Product is registered (one pipeline stage), then arithmetic-shifted right by `GAIN_SHIFT`, truncating toward −inf.
  - The result is saturated to 16b signed range [0x8000, 0x7FFF].
- Accumulation:
  - Saturated terms accumulate into the left or right 19b signed accumulator on the cycle after issue (cycles 2–11).
  - 19 bits cannot overflow with five 16b terms.
- DRAIN (cycle 11): last accumulate lands. No issue.
- VOL:
  - Each accumulator is saturated to 16b, then multiplied by {1'b0, `volume`} through the same multiplier, shift and saturate path.
  - Issue L at cycle 12 and R at cycle 13.
  - Results load `lft_out` at cycle 13 and `rht_out` at cycle 14.
- DONE (cycle 15): `out_vld` = 1, then return to IDLE.
- `filt_vld` while in any state other than IDLE: input ignored, `ovr` pulses the next cycle, and the in-progress sample is unaffected.
- `filt_vld` in DONE is also dropped. A new capture is legal from IDLE only, on cycle 16 at the earliest.

## Timing
- Fixed latency: `out_vld` is asserted 15 cycles after the capturing edge.
- Sustained throughput: one sample per 16 cycles.
- `lft_out` updates one cycle before `rht_out`. Both are stable and valid together during `out_vld`.
- Reset values: `lft_out` = 0, `rht_out` = 0, `out_vld` = 0, `busy` = 0, `ovr` = 0; state = IDLE; accumulators and holding registers = 0.
- Reset mid-sequence: all of the above apply immediately and asynchronously. No `out_vld` is produced for the aborted sample.
- `busy` is combinationally derived from state ≠ IDLE.

## Structure
- Package `eq_pkg` holds:
  - the state enum `eq_seq_state_t`;
  - the band-index enum (LP, B1, B2, B3, HP);
  - constants `AUDIO_W` = 16, `POT_W` = 12, `ACC_W` = 19, `GAIN_SHIFT` = 11;
  - a `sat16` function that saturates a wider signed value to 16 bits.
- Sub-module `sat_mult`: the single registered signed 16×13 multiplier followed by shift and saturate, with a one-cycle latency.
- The operand mux and state machine live in the top module.

## Test plan
- Unity path: LP_lft = 0x1000, LP_gain = 0x800, other gains = 0, volume = 0x800 → `lft_out` = 0x1000, `rht_out` = 0, `out_vld` exactly 15 cycles after `filt_vld`.
- Sum: all ten bands = 0x0100, all gains = 0x800, volume = 0x400 → `lft_out` = `rht_out` = 0x0280.
- Saturation:
  - All left bands = 0x7FFF, gains = 0xFFF, volume = 0x800 → `lft_out` = 0x7FFF.
  - All right bands = 0x8000, same gains and volume → `rht_out` = 0x8000.
- Truncation: LP_lft = 0xFFFF (−1), LP_gain = 0x400, volume = 0x800 → `lft_out` = 0xFFFF (−1, floor of −0.5).
- Overrun: second `filt_vld` at cycle 5 → `ovr` pulses at cycle 6. First result is correct; only one `out_vld`. Change pots at cycle 3 → results reflect the captured values.
- Reset: assert `rst_n` = 0 at cycle 8 → all outputs 0 immediately. After release, a new `filt_vld` produces the correct result at +15.

Source files
------------

// File: rtl/eq_scale_sequencer_pkg.sv
// Shared types and constants for the EQ gain/volume sequencer.
package eq_pkg;

  localparam int AUDIO_W    = 16;
  localparam int POT_W      = 12;
  localparam int ACC_W      = 19;
  localparam int GAIN_SHIFT = 11;
  localparam int NUM_BANDS  = 5;

  typedef enum logic [2:0] {
    IDLE,
    BAND,
    DRAIN,
    VOL,
    DONE
  } eq_seq_state_t;

  typedef enum logic [2:0] {
    BAND_LP,
    BAND_B1,
    BAND_B2,
    BAND_B3,
    BAND_HP
  } eq_band_t;

  function automatic logic signed [AUDIO_W-1:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)
      return 16'sh7fff;
    else if (x < -32'sd32768)
      return 16'sh8000;
    else
      return x[AUDIO_W-1:0];
  endfunction

endpackage

// File: rtl/eq_scale_sequencer_sat_mult.sv
// Shared signed 16x13 multiplier: registered product, arithmetic shift, 16b saturation.
module sat_mult
  import eq_pkg::*;
#(
  parameter int SHIFT = GAIN_SHIFT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [AUDIO_W-1:0] a,
  input  logic signed [POT_W:0]     b,
  output logic signed [AUDIO_W-1:0] y
);

  localparam int PROD_W = AUDIO_W + POT_W + 1;

  logic signed [PROD_W-1:0] prod_q;
  logic signed [31:0]       scaled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prod_q <= '0;
    else
      prod_q <= PROD_W'(a) * PROD_W'(b);
  end

  // >>> on a signed value floors toward -inf
  assign scaled = 32'(prod_q >>> SHIFT);
  assign y      = sat16(scaled);

endmodule

// File: rtl/eq_scale_sequencer.sv
// Time-multiplexed band gain / volume scaler for the EQ engine, one shared multiplier.
//
// state | meaning
// IDLE  | waiting for filt_vld; capture audio and pots
// BAND  | issue the ten band multiplies (L0..L4, R0..R4)
// DRAIN | last band term lands in the accumulator
// VOL   | volume multiplies: issue L, issue R / load lft_out, load rht_out
// DONE  | out_vld strobe, both outputs valid
module eq_scale_sequencer
  import eq_pkg::*;
#(
  parameter int GAIN_SHIFT = eq_pkg::GAIN_SHIFT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      filt_vld,
  input  logic signed [AUDIO_W-1:0] LP_lft,
  input  logic signed [AUDIO_W-1:0] B1_lft,
  input  logic signed [AUDIO_W-1:0] B2_lft,
  input  logic signed [AUDIO_W-1:0] B3_lft,
  input  logic signed [AUDIO_W-1:0] HP_lft,
  input  logic signed [AUDIO_W-1:0] LP_rht,
  input  logic signed [AUDIO_W-1:0] B1_rht,
  input  logic signed [AUDIO_W-1:0] B2_rht,
  input  logic signed [AUDIO_W-1:0] B3_rht,
  input  logic signed [AUDIO_W-1:0] HP_rht,
  input  logic        [POT_W-1:0]   LP_gain,
  input  logic        [POT_W-1:0]   B1_gain,
  input  logic        [POT_W-1:0]   B2_gain,
  input  logic        [POT_W-1:0]   B3_gain,
  input  logic        [POT_W-1:0]   HP_gain,
  input  logic        [POT_W-1:0]   volume,
  output logic signed [AUDIO_W-1:0] lft_out,
  output logic signed [AUDIO_W-1:0] rht_out,
  output logic                      out_vld,
  output logic                      busy,
  output logic                      ovr
);

  eq_seq_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  logic signed [AUDIO_W-1:0] aud_h [2*NUM_BANDS];
  logic        [POT_W-1:0]   gain_h [NUM_BANDS];
  logic        [POT_W-1:0]   vol_h;
  logic signed [ACC_W-1:0]   acc_l, acc_r;
  logic                      term_vld_q, term_rht_q;

  logic                      capture;
  logic [2:0]                band_idx;
  logic signed [ACC_W-1:0]   acc_sel;
  logic signed [AUDIO_W-1:0] mult_a, mult_y;
  logic signed [POT_W:0]     mult_b;

  assign capture = (state_q == IDLE) && filt_vld;
  assign busy    = (state_q != IDLE);
  assign out_vld = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (filt_vld) begin
          state_d = BAND;
          cnt_d   = '0;
        end
      end
      BAND: begin
        if (cnt_q == 4'd9) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DRAIN: begin
        state_d = VOL;
        cnt_d   = '0;
      end
      VOL: begin
        if (cnt_q == 4'd2) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand mux: band slots 0..4 are left, 5..9 right, sharing the five gains
  always_comb begin
    band_idx = (cnt_q >= 4'd5) ? 3'(cnt_q - 4'd5) : cnt_q[2:0];
    acc_sel  = (cnt_q == 4'd0) ? acc_l : acc_r;
    mult_a   = '0;
    mult_b   = '0;
    case (state_q)
      BAND: begin
        mult_a = aud_h[cnt_q];
        mult_b = {1'b0, gain_h[band_idx]};
      end
      VOL: begin
        mult_a = sat16(32'(acc_sel));
        mult_b = {1'b0, vol_h};
      end
      default: ;
    endcase
  end

  sat_mult #(.SHIFT(GAIN_SHIFT)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (mult_a),
    .b     (mult_b),
    .y     (mult_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2*NUM_BANDS; i++) aud_h[i] <= '0;
      for (int i = 0; i < NUM_BANDS; i++) gain_h[i] <= '0;
      vol_h      <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      term_vld_q <= 1'b0;
      term_rht_q <= 1'b0;
      lft_out    <= '0;
      rht_out    <= '0;
      ovr        <= 1'b0;
    end else begin
      term_vld_q <= (state_q == BAND);
      term_rht_q <= (cnt_q >= 4'd5);
      ovr        <= filt_vld && (state_q != IDLE);

      // Product is one cycle behind the issue, so accumulate from the delayed tags
      if (term_vld_q) begin
        if (term_rht_q)
          acc_r <= acc_r + ACC_W'(mult_y);
        else
          acc_l <= acc_l + ACC_W'(mult_y);
      end

      if (state_q == VOL && cnt_q == 4'd1) lft_out <= mult_y;
      if (state_q == VOL && cnt_q == 4'd2) rht_out <= mult_y;

      if (capture) begin
        aud_h[0] <= LP_lft;
        aud_h[1] <= B1_lft;
        aud_h[2] <= B2_lft;
        aud_h[3] <= B3_lft;
        aud_h[4] <= HP_lft;
        aud_h[5] <= LP_rht;
        aud_h[6] <= B1_rht;
        aud_h[7] <= B2_rht;
        aud_h[8] <= B3_rht;
        aud_h[9] <= HP_rht;
        gain_h[BAND_LP] <= LP_gain;
        gain_h[BAND_B1] <= B1_gain;
        gain_h[BAND_B2] <= B2_gain;
        gain_h[BAND_B3] <= B3_gain;
        gain_h[BAND_HP] <= HP_gain;
        vol_h <= volume;
        acc_l <= '0;
        acc_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_eq_scale_sequencer.sv
// Self-checking bench for eq_scale_sequencer against an arithmetic reference model.
module tb_eq_scale_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic filt_vld = 1'b0;
  logic signed [15:0] bl [5];
  logic signed [15:0] br [5];
  logic [11:0] g [5];
  logic [11:0] vol;
  logic signed [15:0] lft_out, rht_out;
  logic out_vld, busy, ovr;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  eq_scale_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .filt_vld (filt_vld),
    .LP_lft   (bl[0]),
    .B1_lft   (bl[1]),
    .B2_lft   (bl[2]),
    .B3_lft   (bl[3]),
    .HP_lft   (bl[4]),
    .LP_rht   (br[0]),
    .B1_rht   (br[1]),
    .B2_rht   (br[2]),
    .B3_rht   (br[3]),
    .HP_rht   (br[4]),
    .LP_gain  (g[0]),
    .B1_gain  (g[1]),
    .B2_gain  (g[2]),
    .B3_gain  (g[3]),
    .HP_gain  (g[4]),
    .volume   (vol),
    .lft_out  (lft_out),
    .rht_out  (rht_out),
    .out_vld  (out_vld),
    .busy     (busy),
    .ovr      (ovr)
  );

  // Reference model: value * pot / 2048 rounded toward -inf, clamped to 16 bits
  function automatic int clamp16(int x);
    return (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
  endfunction

  function automatic int scale(int a, int pot);
    int p, q;
    p = a * pot;
    q = p / 2048;
    if (p < 0 && q * 2048 != p) q = q - 1;
    return clamp16(q);
  endfunction

  function automatic void model(output logic [15:0] el, output logic [15:0] er);
    int sl, sr;
    sl = 0;
    sr = 0;
    for (int i = 0; i < 5; i++) begin
      sl += scale(int'(bl[i]), int'(g[i]));
      sr += scale(int'(br[i]), int'(g[i]));
    end
    el = 16'(scale(clamp16(sl), int'(vol)));
    er = 16'(scale(clamp16(sr), int'(vol)));
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 5; i++) begin
      bl[i] = '0;
      br[i] = '0;
      g[i]  = '0;
    end
    vol = '0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 5; i++) begin
      bl[i] = 16'($urandom);
      br[i] = 16'($urandom);
      g[i]  = 12'($urandom);
    end
    vol = 12'($urandom);
  endtask

  task automatic fill(input logic [15:0] l, input logic [15:0] r, input logic [11:0] gg,
                      input logic [11:0] v);
    for (int i = 0; i < 5; i++) begin
      bl[i] = l;
      br[i] = r;
      g[i]  = gg;
    end
    vol = v;
  endtask

  // Pulses filt_vld in cycle 0, returns the cycle out_vld was seen (40 on timeout)
  task automatic run_sample(output int lat, output logic [15:0] l, output logic [15:0] r);
    @(negedge clk);
    filt_vld = 1'b1;
    @(negedge clk);
    filt_vld = 1'b0;
    lat = 1;
    while (out_vld !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    l = lft_out;
    r = rht_out;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (lft_out !== 16'h0) begin fails++; $display("FAIL reset_lft got %h want 0000", lft_out); end
    tests_run++;
    if (rht_out !== 16'h0) begin fails++; $display("FAIL reset_rht got %h want 0000", rht_out); end
    tests_run++;
    if ({out_vld, busy, ovr} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got vld/busy/ovr=%b want 000", {out_vld, busy, ovr});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unity();
    int lat;
    logic [15:0] l, r;
    clear_inputs();
    bl[0] = 16'h1000;
    g[0]  = 12'h800;
    vol   = 12'h800;
    run_sample(lat, l, r);
    tests_run++;
    if (lat !== 15) begin fails++; $display("FAIL unity_latency got %0d want 15", lat); end
    tests_run++;
    if (l !== 16'h1000) begin fails++; $display("FAIL unity_lft got %h want 1000", l); end
    tests_run++;
    if (r !== 16'h0000) begin fails++; $display("FAIL unity_rht got %h want 0000", r); end
    tests_run++;
    if (busy !== 1'b1) begin fails++; $display("FAIL unity_busy_at_vld got %b want 1", busy); end
    @(negedge clk);
    tests_run++;
    if ({out_vld, busy} !== 2'b00) begin
      fails++; $display("FAIL unity_after_vld got vld/busy=%b want 00", {out_vld, busy});
    end
  endtask

  task automatic test_sum();
    int lat;
    logic [15:0] l, r;
    fill(16'h0100, 16'h0100, 12'h800, 12'h400);
    run_sample(lat, l, r);
    tests_run++;
    if (l !== 16'h0280 || r !== 16'h0280) begin
      fails++; $display("FAIL sum got l=%h r=%h want 0280/0280", l, r);
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [15:0] l, r;
    fill(16'h7fff, 16'h8000, 12'hfff, 12'h800);
    run_sample(lat, l, r);
    tests_run++;
    if (l !== 16'h7fff) begin fails++; $display("FAIL sat_pos got %h want 7fff", l); end
    tests_run++;
    if (r !== 16'h8000) begin fails++; $display("FAIL sat_neg got %h want 8000", r); end
  endtask

  task automatic test_truncation();
    int lat;
    logic [15:0] l, r;
    clear_inputs();
    bl[0] = 16'hffff;
    g[0]  = 12'h400;
    vol   = 12'h800;
    run_sample(lat, l, r);
    tests_run++;
    if (l !== 16'hffff) begin fails++; $display("FAIL trunc_floor got %h want ffff", l); end
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] l, r, el, er;
    for (int n = 0; n < 12; n++) begin
      rand_inputs();
      model(el, er);
      run_sample(lat, l, r);
      tests_run++;
      if (lat !== 15 || l !== el || r !== er) begin
        fails++;
        $display("FAIL random_%0d got lat=%0d l=%h r=%h want lat=15 l=%h r=%h", n, lat, l, r, el, er);
      end
    end
  endtask

  task automatic test_overrun();
    int n_vld, n_ovr, ovr_cyc, lat;
    logic [15:0] l, r, el, er;
    rand_inputs();
    model(el, er);
    n_vld = 0; n_ovr = 0; ovr_cyc = -1; lat = -1; l = 'x; r = 'x;
    @(negedge clk);
    filt_vld = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (ovr === 1'b1) begin n_ovr++; ovr_cyc = c; end
      if (out_vld === 1'b1) begin n_vld++; lat = c; l = lft_out; r = rht_out; end
      filt_vld = (c == 5);
      if (c == 3) begin
        for (int i = 0; i < 5; i++) g[i] = 12'($urandom);
        vol = 12'($urandom);
      end
      if (c == 5) for (int i = 0; i < 5; i++) begin bl[i] = ~bl[i]; br[i] = ~br[i]; end
    end
    tests_run++;
    if (n_ovr !== 1 || ovr_cyc !== 6) begin
      fails++; $display("FAIL ovr_pulse got count=%0d cycle=%0d want 1 at 6", n_ovr, ovr_cyc);
    end
    tests_run++;
    if (n_vld !== 1 || lat !== 15) begin
      fails++; $display("FAIL ovr_single_vld got count=%0d cycle=%0d want 1 at 15", n_vld, lat);
    end
    tests_run++;
    if (l !== el || r !== er) begin
      fails++; $display("FAIL ovr_result got l=%h r=%h want l=%h r=%h", l, r, el, er);
    end
  endtask

  task automatic test_back_to_back();
    int v_cyc[$], o_cyc[$];
    logic [15:0] v_l[$], v_r[$];
    logic [15:0] ea_l, ea_r, eb_l, eb_r;
    int c0, c1;
    rand_inputs();
    model(ea_l, ea_r);
    @(negedge clk);
    filt_vld = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (out_vld === 1'b1) begin v_cyc.push_back(c); v_l.push_back(lft_out); v_r.push_back(rht_out); end
      if (ovr === 1'b1) o_cyc.push_back(c);
      if (c == 15) begin
        rand_inputs();
        model(eb_l, eb_r);
        filt_vld = 1'b1;
      end else if (c != 16) begin
        filt_vld = 1'b0;
      end
    end
    c0 = (v_cyc.size() > 0) ? v_cyc[0] : -1;
    c1 = (v_cyc.size() > 1) ? v_cyc[1] : -1;
    tests_run++;
    if (v_cyc.size() !== 2 || c0 !== 15 || c1 !== 31) begin
      fails++;
      $display("FAIL b2b_vld_cycles got count=%0d first=%0d second=%0d want 2 at 15,31",
               v_cyc.size(), c0, c1);
    end
    tests_run++;
    if (o_cyc.size() !== 1 || (o_cyc.size() > 0 && o_cyc[0] !== 16)) begin
      fails++; $display("FAIL b2b_done_drop got ovr count=%0d want 1 at cycle 16", o_cyc.size());
    end
    if (v_cyc.size() == 2) begin
      tests_run++;
      if (v_l[0] !== ea_l || v_r[0] !== ea_r || v_l[1] !== eb_l || v_r[1] !== eb_r) begin
        fails++;
        $display("FAIL b2b_results got %h/%h %h/%h want %h/%h %h/%h",
                 v_l[0], v_r[0], v_l[1], v_r[1], ea_l, ea_r, eb_l, eb_r);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, n_vld;
    logic [15:0] l, r, el, er;
    fill(16'h0100, 16'h0100, 12'h800, 12'h400);
    run_sample(lat, l, r);
    rand_inputs();
    @(negedge clk);
    filt_vld = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      filt_vld = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (lft_out !== 16'h0 || rht_out !== 16'h0) begin
      fails++; $display("FAIL midreset_outs got l=%h r=%h want 0000/0000", lft_out, rht_out);
    end
    tests_run++;
    if ({out_vld, busy, ovr} !== 3'b000) begin
      fails++; $display("FAIL midreset_flags got vld/busy/ovr=%b want 000", {out_vld, busy, ovr});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_vld = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_vld === 1'b1 || busy === 1'b1) n_vld++;
    end
    tests_run++;
    if (n_vld !== 0) begin fails++; $display("FAIL midreset_abort got %0d active cycles want 0", n_vld); end
    rand_inputs();
    model(el, er);
    run_sample(lat, l, r);
    tests_run++;
    if (lat !== 15 || l !== el || r !== er) begin
      fails++;
      $display("FAIL midreset_recover got lat=%0d l=%h r=%h want lat=15 l=%h r=%h", lat, l, r, el, er);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_sum();
    test_saturation();
    test_truncation();
    test_random();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
